t5_fetch: RTL and testbench

Instruction fetch stage of the T5 RV32 pipeline, sitting directly upstream of the decode stage. It owns the fetch program counter, runs classic Wishbone read cycles on the instruction bus, and presents each instruction word with its address to decode. It absorbs bus stalls and pipeline stalls with a one-entry hold buffer, and handles control-flow redirects from execute, including discarding responses that are already in flight.

---
 rtl/t5_fetch_pkg.sv | 15 +
 rtl/t5_fetch_buf.sv | 35 +++
 rtl/t5_fetch.sv | 175 +++++++++++++++++
 tb/tb_t5_fetch.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t5_fetch_pkg.sv
// Shared definitions for the T5 fetch stage: FSM encodings, the NOP word and the default reset PC.
package t5_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] T5_NOP      = 32'h0000_0013;
    localparam logic [31:0] T5_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/t5_fetch_buf.sv
// One-entry hold buffer that parks a fetched word while decode is stalled.
module t5_fetch_buf
    import t5_fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] din,
    input  logic [XLEN-1:0] pin,
    output logic [XLEN-1:0] dout,
    output logic [XLEN-1:0] pout,
    output logic            full
);

    always_ff @(posedge sclk) begin
        if (srst) begin
            full <= 1'b0;
            dout <= T5_NOP;
            pout <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
            pout <= pin;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/t5_fetch.sv
// T5 RV32 instruction fetch: owns the fetch PC, runs Wishbone reads and feeds decode.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// FETCH | request outstanding at iwb_adr, streaming words to decode
// HOLD  | decode stalled, one word parked in the hold buffer, bus idle
// DRAIN | redirect arrived mid-request; waiting for the stale ack to drop it
// HALT  | misaligned redirect target; idle until an aligned redirect
module t5_fetch
    import t5_fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = T5_RESET_PC
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic            bra,
    input  logic [XLEN-1:0] bpc,
    output logic [XLEN-3:0] iwb_adr,
    output logic            iwb_stb,
    input  logic            iwb_ack,
    input  logic [XLEN-1:0] iwb_dat,
    output logic [XLEN-1:0] fins,
    output logic [XLEN-1:0] fpc,
    output logic            fvld,
    output logic            fmis
);

    fetch_state_e    state, state_nxt;
    logic            stb_nxt, fvld_nxt, fmis_nxt;
    logic            drain_halt, dhalt_nxt;
    logic [XLEN-3:0] adr_nxt, tgt, tgt_nxt;
    logic [XLEN-1:0] fins_nxt, fpc_nxt;
    logic            buf_load, buf_unload, buf_clear, buf_full;
    logic [XLEN-1:0] buf_dat, buf_pc;
    logic            ack, pend, ofree, bra_ok;

    assign ack    = iwb_stb & iwb_ack;
    assign pend   = iwb_stb & ~iwb_ack;
    assign ofree  = sena | ~fvld;
    assign bra_ok = (bpc[1:0] == 2'b00);

    t5_fetch_buf #(.XLEN(XLEN)) u_buf (
        .sclk   (sclk),
        .srst   (srst),
        .load   (buf_load),
        .unload (buf_unload),
        .clear  (buf_clear),
        .din    (iwb_dat),
        .pin    ({iwb_adr, 2'b00}),
        .dout   (buf_dat),
        .pout   (buf_pc),
        .full   (buf_full)
    );

    always_ff @(posedge sclk) begin
        if (srst) begin
            state      <= ST_IDLE;
            iwb_stb    <= 1'b0;
            iwb_adr    <= RESET_PC[XLEN-1:2];
            tgt        <= '0;
            drain_halt <= 1'b0;
            fins       <= T5_NOP;
            fpc        <= RESET_PC;
            fvld       <= 1'b0;
            fmis       <= 1'b0;
        end else begin
            state      <= state_nxt;
            iwb_stb    <= stb_nxt;
            iwb_adr    <= adr_nxt;
            tgt        <= tgt_nxt;
            drain_halt <= dhalt_nxt;
            fins       <= fins_nxt;
            fpc        <= fpc_nxt;
            fvld       <= fvld_nxt;
            fmis       <= fmis_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stb_nxt    = iwb_stb;
        adr_nxt    = iwb_adr;
        tgt_nxt    = tgt;
        dhalt_nxt  = drain_halt;
        fins_nxt   = fins;
        fpc_nxt    = fpc;
        fvld_nxt   = fvld;
        fmis_nxt   = fmis;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;

        // decode took the current word; a bubble follows unless a new one loads below
        if (sena) begin
            fvld_nxt = 1'b0;
            fins_nxt = T5_NOP;
        end

        if (bra) begin
            fvld_nxt  = 1'b0;
            fins_nxt  = T5_NOP;
            buf_clear = 1'b1;
            if (!bra_ok) begin
                fmis_nxt = 1'b1;
                if (pend) begin
                    dhalt_nxt = 1'b1;
                    state_nxt = ST_DRAIN;
                end else begin
                    stb_nxt   = 1'b0;
                    state_nxt = ST_HALT;
                end
            end else if (pend) begin
                tgt_nxt   = bpc[XLEN-1:2];
                dhalt_nxt = 1'b0;
                state_nxt = ST_DRAIN;
            end else begin
                adr_nxt   = bpc[XLEN-1:2];
                stb_nxt   = 1'b1;
                state_nxt = ST_FETCH;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    stb_nxt   = 1'b1;
                    state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (ack) begin
                        adr_nxt = iwb_adr + 1'b1;
                        if (ofree) begin
                            fins_nxt = iwb_dat;
                            fpc_nxt  = {iwb_adr, 2'b00};
                            fvld_nxt = 1'b1;
                        end else begin
                            buf_load  = 1'b1;
                            stb_nxt   = 1'b0;
                            state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sena && buf_full) begin
                        fins_nxt   = buf_dat;
                        fpc_nxt    = buf_pc;
                        fvld_nxt   = 1'b1;
                        buf_unload = 1'b1;
                        stb_nxt    = 1'b1;
                        state_nxt  = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (ack) begin
                        if (drain_halt) begin
                            stb_nxt   = 1'b0;
                            state_nxt = ST_HALT;
                        end else begin
                            adr_nxt   = tgt;
                            state_nxt = ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    stb_nxt = 1'b0;
                end
                default: begin
                    stb_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t5_fetch.sv
// Bench for t5_fetch: modelled Wishbone slave, expected-word scoreboard, one task per scenario.
module tb_t5_fetch;

    logic        sclk;
    logic        srst;
    logic        sena;
    logic        bra;
    logic [31:0] bpc;
    logic [29:0] iwb_adr;
    logic        iwb_stb;
    logic        iwb_ack;
    logic [31:0] iwb_dat;
    logic [31:0] fins;
    logic [31:0] fpc;
    logic        fvld;
    logic        fmis;

    logic        ack_en;
    logic        mon_en;
    int          total;
    int          bad;

    logic [31:0] exp_q[$];
    logic [31:0] obs_pc [1024];
    logic [31:0] obs_ins[1024];
    int          obs_cnt;
    int          rd_idx;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'h5A5A_0013;
    endfunction

    t5_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .sclk    (sclk),
        .srst    (srst),
        .sena    (sena),
        .bra     (bra),
        .bpc     (bpc),
        .iwb_adr (iwb_adr),
        .iwb_stb (iwb_stb),
        .iwb_ack (iwb_ack),
        .iwb_dat (iwb_dat),
        .fins    (fins),
        .fpc     (fpc),
        .fvld    (fvld),
        .fmis    (fmis)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    assign iwb_ack = iwb_stb & ack_en;
    assign iwb_dat = mem_word({iwb_adr, 2'b00});

    initial obs_cnt = 0;
    always @(negedge sclk) begin
        if (mon_en && !srst && fvld && sena) begin
            obs_pc[obs_cnt % 1024]  = fpc;
            obs_ins[obs_cnt % 1024] = fins;
            obs_cnt = obs_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int b;
        b = budget;
        while ((obs_cnt - rd_idx) < n && b > 0) begin
            tick(1);
            b--;
        end
        ok = ((obs_cnt - rd_idx) >= n);
    endtask

    task automatic do_reset();
        srst   = 1'b1;
        sena   = 1'b0;
        bra    = 1'b0;
        bpc    = 32'h0;
        ack_en = 1'b1;
        mon_en = 1'b1;
        tick(2);
        srst   = 1'b0;
        exp_q.delete();
        rd_idx = obs_cnt;
    endtask

    task automatic test_reset();
        srst   = 1'b1;
        sena   = 1'b0;
        bra    = 1'b0;
        bpc    = 32'h0;
        ack_en = 1'b1;
        mon_en = 1'b1;
        tick(2);
        total++; if (iwb_stb !== 1'b0)  begin bad++; $display("FAIL reset_stb got=%b want=0", iwb_stb); end
        total++; if (iwb_adr !== 30'h0) begin bad++; $display("FAIL reset_adr got=%h want=0", iwb_adr); end
        total++; if (fins !== NOP)      begin bad++; $display("FAIL reset_fins got=%h want=%h", fins, NOP); end
        total++; if (fpc !== 32'h0)     begin bad++; $display("FAIL reset_fpc got=%h want=0", fpc); end
        total++; if (fvld !== 1'b0)     begin bad++; $display("FAIL reset_fvld got=%b want=0", fvld); end
        total++; if (fmis !== 1'b0)     begin bad++; $display("FAIL reset_fmis got=%b want=0", fmis); end
        srst = 1'b0;
        rd_idx = obs_cnt;
    endtask

    task automatic test_stream();
        bit          ok;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        sena = 1'b1;
        tick(1);
        total++; if (iwb_stb !== 1'b1 || fvld !== 1'b0) begin bad++; $display("FAIL stream_idle stb=%b fvld=%b want stb=1 fvld=0", iwb_stb, fvld); end
        tick(1);
        total++; if (fvld !== 1'b1 || fpc !== 32'h0) begin bad++; $display("FAIL stream_first fvld=%b fpc=%h want 1/0", fvld, fpc); end
        wait_obs(16, 60, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL stream_timeout got=%0d want=16", obs_cnt - rd_idx); end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_pc[rd_idx % 1024] !== e || obs_ins[rd_idx % 1024] !== mem_word(e)) begin
                bad++; $display("FAIL stream_word pc=%h ins=%h want pc=%h ins=%h", obs_pc[rd_idx % 1024], obs_ins[rd_idx % 1024], e, mem_word(e));
            end
            rd_idx++;
        end
        rd_idx = obs_cnt;
    endtask

    task automatic test_stall();
        bit          ok;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
        sena = 1'b1;
        tick(6);
        sena = 1'b0;
        tick(1);
        total++; if (iwb_stb !== 1'b0 || fvld !== 1'b1) begin bad++; $display("FAIL stall_hold stb=%b fvld=%b want stb=0 fvld=1", iwb_stb, fvld); end
        tick(2);
        total++; if (iwb_stb !== 1'b0) begin bad++; $display("FAIL stall_stb_low got=%b want=0", iwb_stb); end
        sena = 1'b1;
        tick(1);
        total++; if (iwb_stb !== 1'b1 || fvld !== 1'b1) begin bad++; $display("FAIL stall_resume stb=%b fvld=%b want 1/1", iwb_stb, fvld); end
        wait_obs(12, 60, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=%0d want=12", obs_cnt - rd_idx); end
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_pc[rd_idx % 1024] !== e || obs_ins[rd_idx % 1024] !== mem_word(e)) begin
                bad++; $display("FAIL stall_word pc=%h ins=%h want pc=%h ins=%h", obs_pc[rd_idx % 1024], obs_ins[rd_idx % 1024], e, mem_word(e));
            end
            rd_idx++;
        end
        rd_idx = obs_cnt;
    endtask

    task automatic test_redirect_ack();
        bit          ok;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h80 + 32'(i * 4));
        sena = 1'b1;
        wait_obs(8, 40, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rack_pre_timeout got=%0d want=8", obs_cnt - rd_idx); end
        bra = 1'b1;
        bpc = 32'h80;
        tick(1);
        bra = 1'b0;
        sena = 1'b1;
        total++; if (fvld !== 1'b0 || iwb_stb !== 1'b1 || iwb_adr !== 30'h20) begin
            bad++; $display("FAIL rack_redirect fvld=%b stb=%b adr=%h want 0/1/20", fvld, iwb_stb, iwb_adr);
        end
        tick(1);
        total++; if (fvld !== 1'b1 || fpc !== 32'h80) begin bad++; $display("FAIL rack_latency fvld=%b fpc=%h want 1/80", fvld, fpc); end
        wait_obs(12, 40, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rack_timeout got=%0d want=12", obs_cnt - rd_idx); end
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_pc[rd_idx % 1024] !== e || obs_ins[rd_idx % 1024] !== mem_word(e)) begin
                bad++; $display("FAIL rack_word pc=%h ins=%h want pc=%h ins=%h", obs_pc[rd_idx % 1024], obs_ins[rd_idx % 1024], e, mem_word(e));
            end
            rd_idx++;
        end
        rd_idx = obs_cnt;
    endtask

    task automatic test_redirect_inflight(input bit second, input logic [31:0] final_tgt);
        bit          ok;
        int          b;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 8; i++) exp_q.push_back(final_tgt + 32'(i * 4));
        sena = 1'b1;
        b = 60;
        while (iwb_adr !== 30'h10 && b > 0) begin
            tick(1);
            b--;
        end
        total++; if (iwb_adr !== 30'h10) begin bad++; $display("FAIL infl_reach adr=%h want=10", iwb_adr); end
        ack_en = 1'b0;
        bra    = 1'b1;
        bpc    = 32'h100;
        tick(1);
        total++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h10 || fvld !== 1'b0) begin
            bad++; $display("FAIL infl_drain stb=%b adr=%h fvld=%b want 1/10/0", iwb_stb, iwb_adr, fvld);
        end
        if (second) bpc = final_tgt;
        else        bra = 1'b0;
        tick(1);
        bra = 1'b0;
        total++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h10) begin
            bad++; $display("FAIL infl_hold stb=%b adr=%h want 1/10", iwb_stb, iwb_adr);
        end
        ack_en = 1'b1;
        wait_obs(24, 60, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL infl_timeout got=%0d want=24", obs_cnt - rd_idx); end
        for (int i = 0; i < 24; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_pc[rd_idx % 1024] !== e || obs_ins[rd_idx % 1024] !== mem_word(e)) begin
                bad++; $display("FAIL infl_word pc=%h ins=%h want pc=%h ins=%h", obs_pc[rd_idx % 1024], obs_ins[rd_idx % 1024], e, mem_word(e));
            end
            rd_idx++;
        end
        rd_idx = obs_cnt;
    endtask

    task automatic test_misaligned();
        bit          ok;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        sena = 1'b1;
        wait_obs(4, 30, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL mis_pre_timeout got=%0d want=4", obs_cnt - rd_idx); end
        bra = 1'b1;
        bpc = 32'h102;
        tick(1);
        bra = 1'b0;
        bpc = 32'h0;
        sena = 1'b1;
        total++; if (fmis !== 1'b1 || fvld !== 1'b0) begin bad++; $display("FAIL mis_flag fmis=%b fvld=%b want 1/0", fmis, fvld); end
        for (int i = 0; i < 4; i++) begin
            total++; if (iwb_stb !== 1'b0) begin bad++; $display("FAIL mis_halt_stb cycle=%0d got=%b want=0", i, iwb_stb); end
            tick(1);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i * 4));
        bra = 1'b1;
        bpc = 32'h200;
        tick(1);
        bra = 1'b0;
        wait_obs(8, 30, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL mis_timeout got=%0d want=8", obs_cnt - rd_idx); end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_pc[rd_idx % 1024] !== e || obs_ins[rd_idx % 1024] !== mem_word(e)) begin
                bad++; $display("FAIL mis_word pc=%h ins=%h want pc=%h ins=%h", obs_pc[rd_idx % 1024], obs_ins[rd_idx % 1024], e, mem_word(e));
            end
            rd_idx++;
        end
        rd_idx = obs_cnt;
        total++; if (fmis !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b want=1", fmis); end
    endtask

    task automatic test_reset_wait();
        bit          ok;
        logic [29:0] held;
        logic [31:0] e;
        mon_en = 1'b0;
        ack_en = 1'b0;
        sena   = 1'b1;
        tick(3);
        total++; if (iwb_stb !== 1'b1 || fvld !== 1'b0) begin bad++; $display("FAIL rw_wait stb=%b fvld=%b want 1/0", iwb_stb, fvld); end
        held = iwb_adr;
        tick(1);
        total++; if (iwb_adr !== held) begin bad++; $display("FAIL rw_adr_hold got=%h want=%h", iwb_adr, held); end
        srst = 1'b1;
        tick(1);
        total++; if (iwb_stb !== 1'b0)  begin bad++; $display("FAIL rw_stb got=%b want=0", iwb_stb); end
        total++; if (iwb_adr !== 30'h0) begin bad++; $display("FAIL rw_adr got=%h want=0", iwb_adr); end
        total++; if (fins !== NOP || fpc !== 32'h0 || fvld !== 1'b0) begin
            bad++; $display("FAIL rw_out fins=%h fpc=%h fvld=%b want %h/0/0", fins, fpc, fvld, NOP);
        end
        total++; if (fmis !== 1'b0)     begin bad++; $display("FAIL rw_fmis got=%b want=0", fmis); end
        srst   = 1'b0;
        ack_en = 1'b1;
        mon_en = 1'b1;
        rd_idx = obs_cnt;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        wait_obs(4, 30, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rw_timeout got=%0d want=4", obs_cnt - rd_idx); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_pc[rd_idx % 1024] !== e || obs_ins[rd_idx % 1024] !== mem_word(e)) begin
                bad++; $display("FAIL rw_word pc=%h ins=%h want pc=%h ins=%h", obs_pc[rd_idx % 1024], obs_ins[rd_idx % 1024], e, mem_word(e));
            end
            rd_idx++;
        end
        rd_idx = obs_cnt;
    endtask

    task automatic test_wrap();
        bit          ok;
        logic [31:0] e;
        do_reset();
        exp_q.push_back(32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        bra  = 1'b1;
        bpc  = 32'hFFFF_FFFC;
        sena = 1'b1;
        tick(1);
        bra = 1'b0;
        bpc = 32'h0;
        wait_obs(4, 30, ok);
        sena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=%0d want=4", obs_cnt - rd_idx); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_pc[rd_idx % 1024] !== e || obs_ins[rd_idx % 1024] !== mem_word(e)) begin
                bad++; $display("FAIL wrap_word pc=%h ins=%h want pc=%h ins=%h", obs_pc[rd_idx % 1024], obs_ins[rd_idx % 1024], e, mem_word(e));
            end
            rd_idx++;
        end
        rd_idx = obs_cnt;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rd_idx = 0;
        srst   = 1'b1;
        sena   = 1'b0;
        bra    = 1'b0;
        bpc    = 32'h0;
        ack_en = 1'b1;
        mon_en = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_ack();
        test_redirect_inflight(1'b0, 32'h100);
        test_redirect_inflight(1'b1, 32'h300);
        test_misaligned();
        test_reset_wait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
